// File: rtl/mnist_pkg.sv
// Shared MNIST classifier types: bucket count, weight-code encoding and the 8-bit count word
// exchanged between the per-neuron bucket counters and the counter_adder score stage.
package mnist_pkg;

    localparam int NUM_BUCKETS = 13;
    localparam int CODE_W      = 4;
    localparam int CNT_W       = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    // Power-of-two weight per code; codes 13..15 carry zero weight and are never counted.
    typedef enum logic [CODE_W-1:0] {
        WCODE_NEG_0P25     = 4'd0,
        WCODE_NEG_0P125    = 4'd1,
        WCODE_NEG_0P0625   = 4'd2,
        WCODE_NEG_0P03125  = 4'd3,
        WCODE_NEG_0P015625 = 4'd4,
        WCODE_POS_0P015625 = 4'd5,
        WCODE_POS_0P03125  = 4'd6,
        WCODE_POS_0P0625   = 4'd7,
        WCODE_POS_0P125    = 4'd8,
        WCODE_POS_0P25     = 4'd9,
        WCODE_POS_0P5      = 4'd10,
        WCODE_POS_1P0      = 4'd11,
        WCODE_POS_2P0      = 4'd12,
        WCODE_ZERO         = 4'd13
    } wcode_e;

endpackage

// File: rtl/weight_bucket_counter_if.sv
// Pixel/weight input stream and registered bucket-count output of one weight_bucket_counter.
interface weight_bucket_counter_if
    import mnist_pkg::*;
#(
    parameter int LANES = 8
) ();

    logic                             in_valid;
    logic                             in_ready;
    logic                             in_last;
    logic [LANES-1:0]                 in_pix;
    logic [LANES-1:0][CODE_W-1:0]     in_code;

    logic                             out_valid;
    logic                             out_ready;
    cnt_t [NUM_BUCKETS-1:0]           out_cnt;
    logic                             out_ovf;

    modport master (
        output in_valid,
        input  in_ready,
        output in_last,
        output in_pix,
        output in_code,
        input  out_valid,
        output out_ready,
        input  out_cnt,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_last,
        input  in_pix,
        input  in_code,
        output out_valid,
        input  out_ready,
        output out_cnt,
        output out_ovf
    );

endinterface

// File: rtl/lane_bucket_popcount.sv
// Per-beat histogram: for each weight bucket, the number of lanes carrying an active pixel
// with that bucket's code. Purely combinational.
module lane_bucket_popcount
    import mnist_pkg::*;
#(
    parameter  int LANES  = 8,
    localparam int BEAT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]                   in_pix,
    input  logic [LANES-1:0][CODE_W-1:0]       in_code,
    output logic [NUM_BUCKETS-1:0][BEAT_W-1:0] beat_cnt
);

    // Zero-weight codes 13..15 never match a bucket index, so they drop out naturally.
    always_comb begin
        beat_cnt = '0;
        for (int b = 0; b < NUM_BUCKETS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                if (in_pix[l] && (in_code[l] == CODE_W'(b))) begin
                    beat_cnt[b] = beat_cnt[b] + BEAT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/weight_bucket_counter.sv
// Per-neuron weight-bucket counter: accumulates active pixels per weight bucket over a frame and
// holds the counts for counter_adder. Define WBC_SATURATE_EN to saturate at 255 and report out_ovf.
module weight_bucket_counter
    import mnist_pkg::*;
#(
    parameter int LANES = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    weight_bucket_counter_if.slave bus
);

    localparam int BEAT_W = $clog2(LANES + 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]                         state_q;
    logic [0:0]                         state_nxt;
    cnt_t [NUM_BUCKETS-1:0]             acc_q;
    cnt_t [NUM_BUCKETS-1:0]             out_cnt_q;
    cnt_t [NUM_BUCKETS-1:0]             sum_cnt;
    logic [NUM_BUCKETS-1:0][BEAT_W-1:0] beat_cnt;
    logic                               accept;
    logic                               accept_last;

    lane_bucket_popcount #(
        .LANES (LANES)
    ) u_popcount (
        .in_pix   (bus.in_pix),
        .in_code  (bus.in_code),
        .beat_cnt (beat_cnt)
    );

    // Any held result stalls every input beat, not only a closing one, until it is taken.
    assign bus.in_ready  = rst_n && ((state_q == ST_EMPTY) || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign accept_last   = accept && bus.in_last;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_cnt   = out_cnt_q;

    always_comb begin
        state_nxt = state_q;
        if (accept_last) begin
            state_nxt = ST_FULL;
        end else if ((state_q == ST_FULL) && bus.out_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

`ifdef WBC_SATURATE_EN
    localparam int SUM_W = CNT_W + 1;

    logic [NUM_BUCKETS-1:0][SUM_W-1:0] sum_wide;
    logic                              beat_sat;
    logic                              ovf_acc_q;
    logic                              out_ovf_q;

    always_comb begin
        sum_wide = '0;
        sum_cnt  = '0;
        beat_sat = 1'b0;
        for (int b = 0; b < NUM_BUCKETS; b++) begin
            sum_wide[b] = SUM_W'(acc_q[b]) + SUM_W'(beat_cnt[b]);
            if (sum_wide[b][CNT_W]) begin
                sum_cnt[b] = '1;
                beat_sat   = 1'b1;
            end else begin
                sum_cnt[b] = sum_wide[b][CNT_W-1:0];
            end
        end
    end

    // Overflow is sticky across a frame and travels with the counts at frame close.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_acc_q <= 1'b0;
            out_ovf_q <= 1'b0;
        end else if (accept_last) begin
            out_ovf_q <= ovf_acc_q | beat_sat;
            ovf_acc_q <= 1'b0;
        end else if (accept) begin
            ovf_acc_q <= ovf_acc_q | beat_sat;
        end
    end

    assign bus.out_ovf = out_ovf_q;
`else
    always_comb begin
        sum_cnt = '0;
        for (int b = 0; b < NUM_BUCKETS; b++) begin
            sum_cnt[b] = acc_q[b] + cnt_t'(beat_cnt[b]);
        end
    end

    assign bus.out_ovf = 1'b0;
`endif

    // The closing beat's own counts go straight into out_cnt while the accumulators restart at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            acc_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept_last) begin
                out_cnt_q <= sum_cnt;
                acc_q     <= '0;
            end else if (accept) begin
                acc_q <= sum_cnt;
            end
        end
    end

endmodule

// File: tb/tb_weight_bucket_counter.sv
// Directed bench for weight_bucket_counter with 8 lanes; overflow expectations follow the
// WBC_SATURATE_EN build setting.
module tb_weight_bucket_counter;
    import mnist_pkg::*;

    localparam int LANES = 8;

`ifdef WBC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    weight_bucket_counter_if #(.LANES(LANES)) bus ();

    weight_bucket_counter #(
        .LANES (LANES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_cnt(input string tag, input cnt_t [NUM_BUCKETS-1:0] observed,
                             input cnt_t [NUM_BUCKETS-1:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat was taken.
    task automatic apply_stimulus(input logic [LANES-1:0] pix,
                                  input logic [LANES-1:0][CODE_W-1:0] code, input logic last);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_pix   = pix;
        bus.in_code  = code;
        bus.in_last  = last;
        #1;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check_bit("accept_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        cnt_t [NUM_BUCKETS-1:0]       exp_cnt;
        cnt_t [NUM_BUCKETS-1:0]       frame_a;
        logic [LANES-1:0][CODE_W-1:0] codes;

        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_pix    = '0;
        bus.in_code   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("reset_in_ready", bus.in_ready, 1'b0);
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check_cnt("reset_out_cnt", bus.out_cnt, '0);
        check_bit("reset_out_ovf", bus.out_ovf, 1'b0);
        rst_n = 1'b1;
        #1;
        check_bit("idle_in_ready", bus.in_ready, 1'b1);

        // Decode: one lane per code 0..7
        for (int l = 0; l < LANES; l++) codes[l] = CODE_W'(l);
        apply_stimulus(8'hFF, codes, 1'b1);
        exp_cnt = '0;
        for (int b = 0; b < 8; b++) exp_cnt[b] = 8'd1;
        check_bit("decode_out_valid", bus.out_valid, 1'b1);
        check_cnt("decode_out_cnt", bus.out_cnt, exp_cnt);
        check_bit("decode_out_ovf", bus.out_ovf, 1'b0);
        check_bit("full_stall_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_bit("drain_out_valid", bus.out_valid, 1'b0);

        // Inactive code-5 lanes and active zero-weight codes
        codes = {4'd13, 4'd15, 4'd14, 4'd13, 4'd5, 4'd5, 4'd5, 4'd5};
        apply_stimulus(8'hF0, codes, 1'b1);
        check_bit("ignored_out_valid", bus.out_valid, 1'b1);
        check_cnt("ignored_out_cnt", bus.out_cnt, '0);
        @(negedge clk);

        // Backpressure: frame A held while frame B waits
        bus.out_ready = 1'b0;
        codes = {LANES{4'd9}};
        apply_stimulus(8'h0F, codes, 1'b0);
        codes = {LANES{4'd10}};
        apply_stimulus(8'h01, codes, 1'b1);
        frame_a     = '0;
        frame_a[9]  = 8'd4;
        frame_a[10] = 8'd1;
        check_cnt("bp_frame_a_cnt", bus.out_cnt, frame_a);
        bus.in_valid = 1'b1;
        bus.in_pix   = 8'hFF;
        bus.in_code  = {LANES{4'd11}};
        bus.in_last  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check_bit("bp_in_ready", bus.in_ready, 1'b0);
            check_bit("bp_out_valid", bus.out_valid, 1'b1);
            check_cnt("bp_hold_cnt", bus.out_cnt, frame_a);
        end
        bus.out_ready = 1'b1;
        codes = {LANES{4'd11}};
        apply_stimulus(8'hFF, codes, 1'b0);
        codes = {LANES{4'd12}};
        apply_stimulus(8'h03, codes, 1'b1);
        exp_cnt     = '0;
        exp_cnt[11] = 8'd8;
        exp_cnt[12] = 8'd2;
        check_bit("bp_frame_b_valid", bus.out_valid, 1'b1);
        check_cnt("bp_frame_b_cnt", bus.out_cnt, exp_cnt);

        // Reset in the middle of a frame
        codes = {LANES{4'd3}};
        for (int i = 0; i < 10; i++) apply_stimulus(8'hFF, codes, 1'b0);
        rst_n = 1'b0;
        #1;
        check_bit("midrst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        check_bit("midrst_out_valid", bus.out_valid, 1'b0);
        check_cnt("midrst_out_cnt", bus.out_cnt, '0);
        rst_n = 1'b1;
        apply_stimulus(8'h04, codes, 1'b1);
        exp_cnt    = '0;
        exp_cnt[3] = 8'd1;
        check_cnt("midrst_new_frame_cnt", bus.out_cnt, exp_cnt);

        // Back-to-back frames with out_ready held high
        codes = {LANES{4'd0}};
        for (int i = 0; i < 4; i++) apply_stimulus(8'hFF, codes, i == 3);
        exp_cnt    = '0;
        exp_cnt[0] = 8'd32;
        check_bit("b2b_a_valid", bus.out_valid, 1'b1);
        check_cnt("b2b_a_cnt", bus.out_cnt, exp_cnt);
        check_bit("b2b_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 2; i++) apply_stimulus(8'hFF, codes, i == 1);
        exp_cnt[0] = 8'd16;
        check_bit("b2b_b_valid", bus.out_valid, 1'b1);
        check_cnt("b2b_b_cnt", bus.out_cnt, exp_cnt);

        // 784 active pixels all in bucket 12
        codes = {LANES{4'd12}};
        for (int i = 0; i < 98; i++) apply_stimulus(8'hFF, codes, i == 97);
        exp_cnt     = '0;
        exp_cnt[12] = SAT_EN ? 8'd255 : 8'd16;
        check_cnt("ovf_out_cnt", bus.out_cnt, exp_cnt);
        check_bit("ovf_out_ovf", bus.out_ovf, SAT_EN);

        // Empty single-beat frame; overflow flag must not carry over
        apply_stimulus(8'h00, codes, 1'b1);
        check_bit("empty_out_valid", bus.out_valid, 1'b1);
        check_cnt("empty_out_cnt", bus.out_cnt, '0);
        check_bit("empty_out_ovf", bus.out_ovf, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/weight_bucket_counter.md
# weight_bucket_counter

- Streams binarised input pixels, each paired with its neuron's quantised weight code.
- Per frame, counts how many active pixels fall into each of the 13 power-of-two weight buckets.
- Presents the 13 8-bit bucket counts as one registered, held-stable vector to the downstream `counter_adder` score stage. It sits directly upstream of that stage, one instance per neuron.

## Interface
- `LANES`, 8, pixel/weight pairs accepted per beat; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_last` in 1: beat is the final beat of a frame.
- `in_pix` in `LANES`: pixel bits, 1 = active.
- `in_code` in `LANES`x4: weight code per lane.
- `out_valid` out 1: `out_cnt` holds a completed frame.
- `out_ready` in 1: consumer has taken `out_cnt`.
- `out_cnt` out 13x8: bucket counts, index 0..12, feeds the score stage `val[0:12]`.
- `out_ovf` out 1: some bucket count exceeded 255 in this frame (see Configuration).

## Operation
- **Code map** (weight of bucket): 0 = -0.25, 1 = -0.125, 2 = -0.0625, 3 = -0.03125, 4 = -0.015625, 5 = +0.015625, 6 = +0.03125, 7 = +0.0625, 8 = +0.125, 9 = +0.25, 10 = +0.5, 11 = +1.0, 12 = +2.0.
- Codes 13..15 mean zero weight and are never counted.
- **Per accepted beat:** for each bucket b, the beat count is the number of lanes with `in_pix=1` and `in_code=b`. Width is `$clog2(LANES+1)`. The beat count is added to accumulator b.
- **Accumulator arithmetic:** 8-bit accumulators; the add is done at 9+ bits, then reduced per Configuration.
- **Frame close:** on an accepted beat with `in_last=1`, load `out_cnt` with accumulator + that beat's counts. In the same edge, clear all accumulators to 0. The next accepted beat starts a new frame from zero.
- **State machine:** two states, EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY→FULL on an accepted last beat.
  - FULL→EMPTY on `out_ready=1` with no accepted last beat.
  - FULL→FULL when `out_ready=1` and an accepted last beat coincide. `out_cnt` reloads with the new frame.
- **Ready rule:** `in_ready = rst_n && (!out_valid || out_ready)`, combinational. While FULL and `out_ready=0`, all input beats stall, not only last beats.
- **Output hold:** `out_cnt` and `out_ovf` are stable whenever `out_valid=1` and no handshake occurs. This holds over the score stage's 2-cycle internal latency.
- **Empty frame:** a frame consisting of a single last beat is legal.

## Timing
- **Reset:** with `rst_n=0` at a clock edge:
  - accumulators = 0, `out_cnt` = all 0, `out_valid` = 0, `out_ovf` = 0;
  - `in_ready` = 0 while `rst_n` is low.
- **Reset mid-frame:** the partial frame is discarded; no output is produced for it.
- **Latency:** the last beat accepted at edge t gives `out_valid=1` and the final `out_cnt` from edge t (visible in cycle t+1).
- **Throughput:** one beat per cycle, with no bubble between frames while `out_ready=1`.
- No combinational path from `in_pix`/`in_code` to any output.
- The only combinational input-to-output path is `out_ready` → `in_ready`.

## Configuration
- `WBC_SATURATE_EN`
  - **Defined:** each accumulator and `out_cnt` saturates at 255. `out_ovf` is set if any bucket saturated during the frame. It is sticky per frame and cleared with the accumulators at frame close.
  - **Undefined:** counts wrap modulo 256 and `out_ovf` is tied to 0.

## Structure
- Shared package `mnist_pkg`:
  - `NUM_BUCKETS = 13`, `CODE_W = 4`;
  - `cnt_t` (8-bit unsigned);
  - `wcode_e` enum of the 13 codes plus `WCODE_ZERO = 13`.
- One sub-module, `lane_bucket_popcount`: combinational, takes `in_pix`/`in_code` and produces the 13 per-beat counts.
- The top level holds the accumulators, the output register, the FSM and the saturation logic.

## Test plan
- **Decode check:** one-beat frame, `LANES=8`, `in_pix=8'hFF`, codes 0..7 → next cycle `out_valid=1`, `out_cnt[0..7]=1`, `out_cnt[8..12]=0`.
- **Overflow:** 98-beat frame (784 pixels), all `in_pix=1`, all codes 12.
  - With `WBC_SATURATE_EN`: `out_cnt[12]=255`, `out_ovf=1`.
  - Without: `out_cnt[12]=16`, `out_ovf=0`.
- **Ignored lanes:** frame with `in_pix=0` on code-5 lanes, and codes 13..15 on active lanes → all `out_cnt=0`.
- **Backpressure:** frame A completes, hold `out_ready=0` for 20 cycles while frame B is offered.
  - `in_ready=0` throughout; `out_cnt` unchanged.
  - Raise `out_ready` → B streams, and B's counts appear correctly.
- **Reset mid-frame:** 10 beats with all lanes code 3 active, then `rst_n=0` for 1 cycle, then a one-beat last frame with a single active code-3 lane → `out_cnt[3]=1`.
- **Back-to-back frames:** `out_ready=1` constantly. Frame A is 4 beats of code 0 (`cnt[0]=32`); frame B starts the next cycle with 2 beats of code 0 → `cnt[0]=16`, with no carry-over from A.
